mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, memory address width; DATA_W, default 8, memory data width; MAX_BURST, default 4, maximum consecutive grants per locked burst (range 2..15).
REQ-002 SHALL have the following ports, in this order:
- i_clk  in  1  sole clock, rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_req[1:0]  in  2  access request per port (port 0 = CPU control unit, port 1 = loader/debug).
- i_we[1:0]  in  2  1 = write, 0 = read, per port.
- i_lock[1:0]  in  2  burst hold request per port.
- i_addr0, i_addr1  in  ADDR_W each  address per port.
- i_wdata0, i_wdata1  in  DATA_W each  write data per port.
- o_gnt[1:0]  out  2  access accepted this cycle, per port.
- o_rvalid[1:0]  out  2  read data valid, per port.
- o_rdata  out  DATA_W  read data, shared by both ports.
- o_mem_en, o_mem_we  out  1 each  RAM enable and write enable.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_wdata  out  DATA_W  RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data, registered inside the RAM with 1-cycle latency.

Function
REQ-003 SHALL assert at most one o_gnt bit per cycle; o_gnt SHALL be combinational from state, pointer and i_req, and the granted access SHALL drive o_mem_* in the same cycle.
REQ-004 SHALL set o_mem_en=1 only in cycles where a grant is issued; o_mem_we, o_mem_addr and o_mem_wdata SHALL come from the granted port; when idle, o_mem_we=0 and the address/data outputs are don't-care, driven to 0.
REQ-005 A requester SHALL hold i_req, i_we, i_addr, i_wdata and i_lock stable until it sees o_gnt; the arbiter SHALL NOT buffer requests.
REQ-006 For a granted read, SHALL assert o_rvalid[p] exactly one cycle after the grant, with o_rdata=i_mem_rdata; writes SHALL produce no o_rvalid.
REQ-007 Throughput SHALL be one access per cycle; back-to-back grants, including alternating ports, SHALL be supported with no bubble.
REQ-008 SHALL keep a last-winner pointer lw, updated on every grant.
- Only one port requesting: that port is granted.
- Both ports requesting in IDLE: port !lw is granted (round-robin).
REQ-009 SHALL implement FSM states IDLE, OWN0, OWN1, stored as a registered state_t.
REQ-010 IDLE->OWNp SHALL occur when port p is granted with i_lock[p]=1; the burst counter SHALL be set to 1.
REQ-011 In OWNp with i_req[p]=1, port p SHALL be granted regardless of the other port, and the counter SHALL increment.
REQ-012 When the counter reaches MAX_BURST while i_req[!p]=1, the FSM SHALL go to IDLE with lw=p, so the other port wins next.
REQ-013 When the counter reaches MAX_BURST while i_req[!p]=0, the counter SHALL reload to 1 and ownership SHALL continue.
REQ-014 In OWNp with i_req[p]=0 or i_lock[p]=0, the FSM SHALL arbitrate in that same cycle as in IDLE and go to IDLE, or to OWNx if the winner x has its lock set.
REQ-015 Simultaneous owner release and other-port request SHALL grant the other port in the same cycle.

Reset
REQ-016 While i_rstn=0 at a rising edge: state=IDLE, lw=1 (port 0 wins the first tie), counter=0, o_rvalid=0, o_gnt=0, o_mem_en=0.
REQ-017 A read granted in the cycle before reset SHALL NOT produce o_rvalid after reset; a reset mid-burst SHALL drop ownership.

Configuration
REQ-018 Macro MEM_ARBITER_BURST_EN:
- Defined: OWN0/OWN1, i_lock and the burst counter behave as in REQ-010..REQ-015.
- Undefined: i_lock ports remain but are ignored, the FSM never leaves IDLE, no counter is synthesized, and arbitration is pure round-robin.

Structure
REQ-019 A shared package mem_arb_pkg SHALL hold the state_t enum (IDLE, OWN0, OWN1) and the port index constants PORT_CPU=0 and PORT_LDR=1.
REQ-020 The priority/round-robin select SHALL be a sub-module rr_select2 (inputs: req[1:0], lw; outputs: one-hot gnt); the FSM, counter and read-return pipeline SHALL live in mem_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- After reset, both ports request a read (addr0=0x10, addr1=0x20) -> cycle 0 grants port 0; next cycle grants port 1; o_rvalid[0] in cycle 1 with RAM[0x10]; o_rvalid[1] in cycle 2 with RAM[0x20].
- Port 1 alone writes 0x5A to 0x33, then port 0 reads 0x33 -> o_rvalid[0] with o_rdata=0x5A.
- With burst enabled, port 1 holds lock and req for 6 accesses while port 0 requests continuously -> grants are p1 x4, p0, p1, ...; with burst disabled -> strict alternation.
- Owner port 0 drops req in OWN0 while port 1 requests -> port 1 granted in that same cycle, with no idle cycle.
- Reset asserted in the cycle after a read grant -> no o_rvalid; state IDLE; next tie goes to port 0.
- Locked owner with no competitor for 10 accesses -> 10 consecutive grants, counter wraps, no gap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   state_t   : arbiter ownership state (IDLE, OWN0, OWN1)
//   PORT_CPU  : port index of the CPU control unit
//   PORT_LDR  : port index of the loader/debug port
//   CNT_W     : burst counter width (holds MAX_BURST up to 15)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_LDR = 1;
   localparam int CNT_W    = 4;

   // One-hot grant vector for a single port index.
   function automatic logic [1:0] port_onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_select2.sv
// ---------------------------------------------------------------------------
// rr_select2
// Two-way round-robin select. A lone requester always wins; on a tie the
// port that did not win last time (!lw) is chosen.
//   req[1:0] : request per port
//   lw       : index of the last winning port
//   gnt[1:0] : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_select2 (
   input  logic [1:0] req,
   input  logic       lw,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = lw ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port RAM with 1-cycle read latency.
// One access per cycle, round-robin between ports, with optional locked
// bursts of up to MAX_BURST consecutive grants for the lock-holding port.
//
// Build option: define MEM_ARBITER_BURST_EN to enable locked bursts
// (OWN0/OWN1 states, burst counter). Without it i_lock is ignored and the
// arbiter is pure round-robin.
//
// Ports:
//   i_clk, i_rstn          : clock, synchronous active-low reset
//   i_req/i_we/i_lock[1:0] : per-port request, write enable, burst lock
//   i_addr0/1, i_wdata0/1  : per-port address and write data
//   o_gnt[1:0]             : combinational grant, at most one bit set
//   o_rvalid[1:0], o_rdata : read return, one cycle after a read grant
//   o_mem_*                : RAM command for the granted access
//   i_mem_rdata            : registered RAM read data
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [1:0]        i_req,
   input  logic [1:0]        i_we,
   input  logic [1:0]        i_lock,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic [1:0]        o_gnt,
   output logic [1:0]        o_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   logic [1:0] rr_gnt;
   logic [1:0] gnt;
   logic       lw_q, lw_d;
   state_t     state_q, state_d;
   logic [1:0] rvalid_q, rvalid_d;

`ifdef MEM_ARBITER_BURST_EN
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner;
   logic             hold;
`else
   logic unused_cfg;
   assign unused_cfg = ^{i_lock, state_q};
`endif

   rr_select2 u_rr_select2 (
      .req (i_req),
      .lw  (lw_q),
      .gnt (rr_gnt)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path through the branches below can infer a latch.
      gnt     = '0;
      state_d = state_q;
      lw_d    = lw_q;
`ifdef MEM_ARBITER_BURST_EN
      cnt_d = cnt_q;
      owner = (state_q == OWN1);
      hold  = (state_q != IDLE) && i_req[owner] && i_lock[owner];
      if (hold) begin
         gnt = port_onehot(owner);
         if (cnt_q + 1'b1 == MAX_CNT) begin
            // Burst limit hit: yield only if the other port is waiting,
            // otherwise keep ownership and start a fresh burst window.
            if (i_req[~owner]) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = CNT_W'(1);
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         // Owner released (or no owner): arbitrate in this same cycle so a
         // waiting port is granted without an idle bubble.
         gnt     = rr_gnt;
         state_d = IDLE;
         cnt_d   = '0;
         if (gnt[PORT_CPU] && i_lock[PORT_CPU]) begin
            state_d = OWN0;
            cnt_d   = CNT_W'(1);
         end else if (gnt[PORT_LDR] && i_lock[PORT_LDR]) begin
            state_d = OWN1;
            cnt_d   = CNT_W'(1);
         end
      end
`else
      gnt     = rr_gnt;
      state_d = IDLE;
`endif
      // No access may reach the RAM while reset is held.
      if (!i_rstn) begin
         gnt = '0;
      end
      if (|gnt) begin
         lw_d = gnt[PORT_LDR];
      end
      rvalid_d = gnt & ~i_we;
   end

   always_comb begin
      o_mem_en    = |gnt;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (gnt[PORT_LDR]) begin
         o_mem_we    = i_we[PORT_LDR];
         o_mem_addr  = i_addr1;
         o_mem_wdata = i_wdata1;
      end else if (gnt[PORT_CPU]) begin
         o_mem_we    = i_we[PORT_CPU];
         o_mem_addr  = i_addr0;
         o_mem_wdata = i_wdata0;
      end
   end

   assign o_gnt    = gnt;
   // Masked during reset so a read granted just before reset never returns.
   assign o_rvalid = rvalid_q & {2{i_rstn}};
   assign o_rdata  = i_mem_rdata;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its _d input.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= IDLE;
         lw_q     <= 1'b1;
         rvalid_q <= '0;
`ifdef MEM_ARBITER_BURST_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         lw_q     <= lw_d;
         rvalid_q <= rvalid_d;
`ifdef MEM_ARBITER_BURST_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
